// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, FSM states and helpers for BCD digit entry
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width needed to count 0..digits inclusive.
    function automatic int cnt_width(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/onehot_bcd_enc.sv
// rtl/onehot_bcd_enc.sv - combinational 10-line one-hot to BCD digit encoder
module onehot_bcd_enc
    import bcd_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic [NUM_KEYS-1:0] key,
    output logic [BCD_W-1:0]    digit,
    output logic                any,
    output logic                multi
);

    always_comb begin
        digit = '0;
        // Later (higher) indices overwrite, so the highest set line wins.
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key[k]) begin
                digit = BCD_W'(k);
            end
        end
        any   = |key;
        multi = (key & (key - NUM_KEYS'(1))) != '0;
        if ((PRIORITY_MODE == 0) && multi) begin
            digit = '0;
        end
    end

endmodule

// File: rtl/bcd_digit_entry.sv
// rtl/bcd_digit_entry.sv - multi-digit BCD entry accumulator with valid/ready output
module bcd_digit_entry
    import bcd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           key_in,
    input  logic                          enter,
    input  logic                          clear,
    output logic [BCD_W*DIGITS-1:0]       acc_bcd,
    output logic [cnt_width(DIGITS)-1:0]  digit_cnt,
    output logic [BCD_W*DIGITS-1:0]       out_bcd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err_multi,
    output logic                          overflow
);

    localparam int ACC_W = BCD_W * DIGITS;
    localparam int CNT_W = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

    state_t               state, state_n;
    logic [NUM_KEYS-1:0]  key_q;
    logic [ACC_W-1:0]     acc_n, out_n;
    logic [CNT_W-1:0]     cnt_n;
    logic                 valid_n, err_n, ovf_n;

    logic [BCD_W-1:0]     enc_digit;
    logic                 enc_any, enc_multi;
    logic                 press;

    onehot_bcd_enc #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_enc (
        .key   (key_in),
        .digit (enc_digit),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // key_q resets to all-ones so a key held through reset is not a press.
    assign press = enc_any && (key_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTRY;
            key_q     <= '1;
            acc_bcd   <= '0;
            digit_cnt <= '0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
            err_multi <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            key_q     <= key_in;
            acc_bcd   <= acc_n;
            digit_cnt <= cnt_n;
            out_bcd   <= out_n;
            out_valid <= valid_n;
            err_multi <= err_n;
            overflow  <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc_bcd;
        cnt_n   = digit_cnt;
        out_n   = out_bcd;
        valid_n = out_valid;
        err_n   = 1'b0;
        ovf_n   = 1'b0;

        if (clear) begin
            acc_n   = '0;
            cnt_n   = '0;
            valid_n = 1'b0;
            state_n = ENTRY;
        end else begin
            case (state)
                ENTRY: begin
                    if (enter && (digit_cnt != '0)) begin
                        out_n   = acc_bcd;
                        valid_n = 1'b1;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else if (press) begin
                        if ((PRIORITY_MODE == 0) && enc_multi) begin
                            err_n = 1'b1;
                        end else if (digit_cnt == CNT_FULL) begin
                            ovf_n = 1'b1;
                        end else begin
                            // Truncating the concatenation drops the oldest digit slot.
                            acc_n = ACC_W'({acc_bcd, enc_digit});
                            cnt_n = digit_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        valid_n = 1'b0;
                        state_n = ENTRY;
                    end
                end
                default: begin
                    state_n = ENTRY;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
Multi-digit decimal entry accumulator, the parametrised successor of the team's 10-line one-hot to BCD encoder. It samples a 10-line one-hot digit bus (keypad/switch style) and detects press events. Each digit is encoded to BCD and shifted into a DIGITS-wide packed BCD accumulator. On enter, the number is presented on a valid/ready output port. It sits between the key-scan front end and the display/arithmetic back end.

Parameters:
DIGITS, 4, number of BCD digits held in the accumulator (>=1)
PRIORITY_MODE, 0, 0 = strict one-hot (multi-hot input is an error); 1 = highest set line wins

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
key_in  input  10  digit lines, bit k = digit k; already synchronised to clk
enter  input  1  commit accumulated number (level, sampled each cycle)
clear  input  1  discard accumulator and any pending output
acc_bcd  output  4*DIGITS  live accumulator, most recent digit in [3:0]
digit_cnt  output  $clog2(DIGITS+1)  digits currently in accumulator
out_bcd  output  4*DIGITS  committed number
out_valid  output  1  out_bcd valid, held until accepted
out_ready  input  1  consumer accepts out_bcd when high with out_valid
err_multi  output  1  one-cycle pulse: multi-hot press rejected (strict mode only)
overflow  output  1  one-cycle pulse: digit dropped, accumulator full

Behaviour:
- Reset (async assert, sync release): acc_bcd=0, digit_cnt=0, out_bcd=0, out_valid=0, err_multi=0, overflow=0, state=ENTRY, key_q=10'h3FF.
- key_q is the registered previous sample of key_in. Press event = (key_in!=0) && (key_q==0). Because key_q resets to all-ones, a key held through reset release registers no press until it is released.
- Encoding: a single set bit k gives digit k. If more than one bit is set: strict mode drops the press and pulses err_multi; priority mode uses the highest set index.
- Latency: acc_bcd and digit_cnt update at the same rising edge that first samples the press. Error and overflow pulses are asserted for exactly the following cycle.
- States: ENTRY, HOLD.
- ENTRY, press with digit_cnt<DIGITS: acc_bcd <= {acc_bcd[4*DIGITS-5:0], digit}; digit_cnt++.
- ENTRY, press with digit_cnt==DIGITS: digit dropped; acc unchanged; overflow pulses.
- ENTRY, enter with digit_cnt>0: out_bcd<=acc_bcd; out_valid<=1; acc_bcd<=0; digit_cnt<=0; go to HOLD.
- ENTRY, enter with digit_cnt==0: ignored.
- HOLD: presses and enter are ignored, with no pulses; key_q still tracks key_in. out_valid&&out_ready moves to ENTRY with out_valid<=0; out_bcd retains its value.
- Priority, highest first: rst > clear > enter > press. A press in the same cycle as enter (ENTRY) is discarded.
- clear (any state): acc_bcd=0, digit_cnt=0, out_valid=0, state=ENTRY; out_bcd retained; no pulses.
- out_bcd is stable while out_valid=1 (standard valid/ready: no retraction).
- Output leading digits are zero-padded; no leading-zero suppression.

Decomposition:
- Package bcd_pkg: BCD_W=4, NUM_KEYS=10, state enum {ENTRY, HOLD}, digit-count width function.
- Sub-module onehot_bcd_enc: combinational 10->4 encoder with PRIORITY_MODE parameter, outputs digit, any, multi. The top level holds edge detection, accumulator, FSM and handshake.

Test Plan:
1. Reset with key_in=10'h004 held, release rst, hold 3 cycles, then key_in=0 then 10'h004 -> no digit on hold; after re-press acc_bcd=16'h0002, digit_cnt=1.
2. Presses 1,9,0,5 (each high 2 cycles, low 2 cycles), enter=1 one cycle, out_ready=0 -> out_bcd=16'h1905, out_valid=1, acc_bcd=0; hold 5 cycles with out_ready=0 and press 7 -> still 16'h1905, acc_bcd=0; out_ready=1 -> out_valid=0 next cycle.
3. DIGITS=4, five presses 1,2,3,4,5 -> acc_bcd=16'h1234, overflow pulse one cycle after press 5, digit_cnt=4.
4. Strict mode, key_in=10'h009 -> err_multi one cycle, acc unchanged. Priority mode, same stimulus -> digit 3 appended.
5. Press 8 in the same cycle as enter with acc=16'h0042 -> out_bcd=16'h0042, acc_bcd=0 (8 discarded). Then clear during HOLD -> out_valid=0, state ENTRY, out_bcd=16'h0042.
6. Assert rst mid-HOLD (asynchronously, between edges) -> all outputs zero immediately, without waiting for a clock edge.
